// File: rtl/pio_pkg.sv
// Shared constants and bus request type for the input PIO register block.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_EDGESEL = 2'd3;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef struct packed {
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
  } avs_req_t;

endpackage

// File: rtl/input_debouncer.sv
// One input bit: two-flop synchronizer followed by a hold-time debouncer.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic q
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Any sample matching q restarts the hold window from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == q) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        q   <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pio_input_capture.sv
// Input PIO: debounced pins, edge capture with per-bit polarity, Avalon-MM
// register file and level interrupt.
module pio_input_capture
  import pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  avs_req_t         req;
  logic [WIDTH-1:0] q, q_d, rise, fall, qual, w1c;
  logic [WIDTH-1:0] edgecap, irqmask, edgesel;
  logic [31:0]      rd_word;
  logic             unused_wdata;

  assign req = '{addr: avs_address, rd: avs_read, wr: avs_write, wdata: avs_writedata};
  assign unused_wdata = ^req.wdata;

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .pin  (pins_in[i]),
      .q    (q[i])
    );
    assign qual[i] = ((edgesel[i] == EDGE_RISE) & rise[i]) |
                     ((edgesel[i] == EDGE_FALL) & fall[i]);
  end

  assign w1c = (req.wr && req.addr == ADDR_EDGECAP) ? req.wdata[WIDTH-1:0] : '0;

  always_comb begin
    rd_word = '0;
    case (req.addr)
      ADDR_DATA:    rd_word[WIDTH-1:0] = q;
      ADDR_IRQMASK: rd_word[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_word[WIDTH-1:0] = edgecap;
      ADDR_EDGESEL: rd_word[WIDTH-1:0] = edgesel;
    endcase
  end

  // Capture is OR'd in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      q_d          <= '0;
      edgecap      <= '0;
      irqmask      <= '0;
      edgesel      <= '0;
      avs_readdata <= '0;
    end else begin
      q_d     <= q;
      edgecap <= (edgecap & ~w1c) | qual;
      if (req.wr && req.addr == ADDR_IRQMASK) irqmask <= req.wdata[WIDTH-1:0];
      if (req.wr && req.addr == ADDR_EDGESEL) edgesel <= req.wdata[WIDTH-1:0];
      if (req.rd) avs_readdata <= rd_word;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule
